// File: rtl/nsc_cmd_writer.sv
// Turns buffered (address, data, last) command words into in-order, single-beat AXI4 writes.
// Optional B-response watchdog is compiled in with `define NSC_WR_TIMEOUT_EN.
module nsc_cmd_writer #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic                cmd_last,
  input  logic                clr_err,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ID_W-1:0]     m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                busy,
  output logic                seq_done,
  output logic [7:0]          wr_count,
  output logic                err,
  output logic [1:0]          err_resp,
  output logic [ADDR_W-1:0]   err_addr,
  output logic                err_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, HALT} state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + DATA_W + 1;

  state_t state, state_next;

  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty, push, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic              last_q;
  logic              issue_done, b_hs, tmo_hit, tmo_fire;

  assign m_awid    = '0;
  assign m_awlen   = 8'd0;
  assign m_awsize  = 3'b010;
  assign m_awburst = 2'b01;
  assign m_wstrb   = '1;
  assign m_wlast   = 1'b1;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign {head_addr, head_data, head_last} = fifo_mem[rd_ptr[PW-1:0]];

  assign busy       = !fifo_empty || (state != IDLE);
  assign issue_done = (!m_awvalid || m_awready) && (!m_wvalid || m_wready);
  assign b_hs       = m_bready && m_bvalid;

  // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge ACLK) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= {cmd_addr, cmd_data, cmd_last};
  end

  // NOTE: ARESETN is asserted high here, so the async edge is posedge.
  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !err) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_done) begin
          state_next = RESP;
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          state_next = HALT;
        end
      end
      RESP: begin
        if (b_hs) begin
          state_next = (m_bresp == 2'b00) ? IDLE : HALT;
        end else if (tmo_hit) begin
          tmo_fire   = 1'b1;
          state_next = HALT;
        end
      end
      HALT: begin
        if (clr_err) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      m_awaddr  <= '0;
      m_wdata   <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      last_q    <= 1'b0;
      seq_done  <= 1'b0;
      wr_count  <= 8'd0;
      err       <= 1'b0;
      err_resp  <= 2'b00;
      err_addr  <= '0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            m_awaddr  <= head_addr;
            m_wdata   <= head_data;
            last_q    <= head_last;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
          end
        end
        ISSUE: begin
          if (m_awvalid && m_awready) m_awvalid <= 1'b0;
          if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
          if (issue_done)             m_bready  <= 1'b1;
        end
        RESP: begin
          if (b_hs) begin
            m_bready <= 1'b0;
            if (m_bresp == 2'b00) begin
              wr_count <= wr_count + 8'd1;
              seq_done <= last_q;
            end else begin
              err      <= 1'b1;
              err_resp <= m_bresp;
              err_addr <= m_awaddr;
            end
          end
        end
        HALT: begin
          if (clr_err) begin
            err      <= 1'b0;
            err_resp <= 2'b00;
          end
        end
        default: ;
      endcase
      // A watchdog expiry abandons the write; any late B is never accepted since bready stays low.
      if (tmo_fire) begin
        m_awvalid <= 1'b0;
        m_wvalid  <= 1'b0;
        m_bready  <= 1'b0;
        err       <= 1'b1;
        err_resp  <= 2'b11;
        err_addr  <= m_awaddr;
      end
    end
  end

`ifdef NSC_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_timeout_q;

  assign tmo_hit     = ((state == ISSUE) || (state == RESP)) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign err_timeout = err_timeout_q;

  always_ff @(posedge ACLK or posedge ARESETN) begin
    if (ARESETN) begin
      tmo_cnt       <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state_next != state)                        tmo_cnt <= '0;
      else if ((state == ISSUE) || (state == RESP))   tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_fire)                                   err_timeout_q <= 1'b1;
      else if ((state == HALT) && clr_err)            err_timeout_q <= 1'b0;
    end
  end
`else
  // Watchdog compiled out; TIMEOUT_CYC only keeps the parameter list identical across builds.
  assign tmo_hit     = 1'b0 && (TIMEOUT_CYC > 0);
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nsc_cmd_writer.sv
// Directed bench for nsc_cmd_writer: a behavioural AXI write slave plus a linear test sequence.
`timescale 1ns/1ps
module tb_nsc_cmd_writer;

  logic        ACLK, ARESETN;
  logic        cmd_valid, cmd_ready, cmd_last, clr_err;
  logic [31:0] cmd_addr, cmd_data;
  logic [31:0] m_awaddr, m_wdata, err_addr;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [11:0] m_awid;
  logic [7:0]  m_awlen, wr_count;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp, err_resp;
  logic [3:0]  m_wstrb;
  logic        busy, seq_done, err, err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Slave model state
  int          aw_lat = 0, w_lat = 0, err_at = -1;
  logic        aw_hold = 1'b0;
  int          aw_cnt, w_cnt;
  logic        aw_v_q, w_v_q, b_r_q;
  logic [31:0] aw_a_q, w_d_q;
  logic [31:0] aw_log[$], w_log[$];
  int          n_aw = 0, n_w = 0, n_b = 0, seq_cnt = 0, seq_at = -1, stab_bad = 0;

  nsc_cmd_writer dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_last(cmd_last), .clr_err(clr_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy), .seq_done(seq_done), .wr_count(wr_count), .err(err), .err_resp(err_resp),
    .err_addr(err_addr), .err_timeout(err_timeout)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Slave acts on the falling edge: first retires the handshakes of the previous rising edge, then drives new readies.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
      aw_cnt = 0; w_cnt = 0; aw_v_q = 1'b0; w_v_q = 1'b0; b_r_q = 1'b0;
    end else begin
      if (aw_v_q && m_awready) begin aw_log.push_back(aw_a_q); n_aw++; end
      else if (aw_v_q && (!m_awvalid || m_awaddr !== aw_a_q)) stab_bad++;
      if (w_v_q && m_wready) begin w_log.push_back(w_d_q); n_w++; end
      else if (w_v_q && (!m_wvalid || m_wdata !== w_d_q)) stab_bad++;
      if (b_r_q && m_bvalid) n_b++;
      if (seq_done) begin seq_cnt++; seq_at = n_b; end
      m_awready = m_awvalid && !aw_hold && (aw_cnt >= aw_lat);
      aw_cnt    = m_awvalid ? aw_cnt + 1 : 0;
      m_wready  = m_wvalid && (w_cnt >= w_lat);
      w_cnt     = m_wvalid ? w_cnt + 1 : 0;
      m_bresp   = (n_b == err_at) ? 2'b10 : 2'b00;
      m_bvalid  = m_bready;
      aw_v_q = m_awvalid; aw_a_q = m_awaddr;
      w_v_q  = m_wvalid;  w_d_q  = m_wdata;
      b_r_q  = m_bready;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge ACLK);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic l, output logic acc);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_last = l;
    acc = cmd_ready;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_b(input int target, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (n_b >= target) break;
      step(1);
    end
    check(tag, 64'(n_b >= target), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, observed running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    logic        acc;
    int          base_aw, base_b;
    logic [31:0] t1_a [4] = '{32'h43C0_4000, 32'h43C0_4004, 32'h43C0_4008, 32'h43C0_3000};
    logic [31:0] t1_d [4] = '{32'h1A4, 32'h100, 32'h100, 32'h1};

    ARESETN = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_last = 1'b0; clr_err = 1'b0;
    step(3);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_wvalid", m_wvalid, 0);
    check("rst_bready", m_bready, 0);
    check("rst_awaddr", m_awaddr, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_err", {err, err_resp, err_timeout}, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("const_attrs", {m_awid, m_awlen, m_awsize, m_awburst, m_wstrb, m_wlast},
          {12'd0, 8'd0, 3'b010, 2'b01, 4'hF, 1'b1});
    ARESETN = 1'b0;
    step(1);

    // T1: four-word sequence, slave always ready
    push(t1_a[0], t1_d[0], 1'b0, acc);
    check("t1_lat_cycle1_awvalid", m_awvalid, 0);
    check("t1_busy", busy, 1);
    push(t1_a[1], t1_d[1], 1'b0, acc);
    check("t1_lat_cycle2_awvalid", {m_awvalid, m_wvalid}, 2'b11);
    check("t1_awaddr", m_awaddr, 32'h43C0_4000);
    check("t1_wdata", m_wdata, 32'h1A4);
    push(t1_a[2], t1_d[2], 1'b0, acc);
    push(t1_a[3], t1_d[3], 1'b1, acc);
    wait_b(4, "t1_b_done");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_aw_order%0d", i), aw_log[i], t1_a[i]);
      check($sformatf("t1_w_order%0d", i), w_log[i], t1_d[i]);
    end
    check("t1_wr_count", wr_count, 4);
    check("t1_seq_cnt", seq_cnt, 1);
    check("t1_seq_at", seq_at, 4);
    check("t1_busy_fall", busy, 0);

    // T2: independent AW/W handshakes
    aw_lat = 0; w_lat = 3;
    push(32'h43C0_2000, 32'hAA, 1'b0, acc);
    step(1);
    check("t2a_both_valid", {m_awvalid, m_wvalid}, 2'b11);
    step(1);
    check("t2a_aw_dropped_first", {m_awvalid, m_wvalid}, 2'b01);
    wait_b(5, "t2a_b_done");
    aw_lat = 3; w_lat = 0;
    push(32'h43C0_2004, 32'hBB, 1'b0, acc);
    step(2);
    check("t2b_w_dropped_first", {m_awvalid, m_wvalid}, 2'b10);
    wait_b(6, "t2b_b_done");
    aw_lat = 0;
    check("t2_counts", {n_aw[15:0], n_w[15:0]}, {16'd6, 16'd6});
    check("t2_data", {aw_log[4], w_log[4], aw_log[5], w_log[5]},
          {32'h43C0_2000, 32'hAA, 32'h43C0_2004, 32'hBB});
    check("t2_stable", stab_bad, 0);
    check("t2_wr_count", wr_count, 6);

    // T3: backpressure until full, 6th push ignored
    aw_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(32'h43C0_1000 + 32'(4 * i), 32'h10 + 32'(i), 1'b0, acc);
      check($sformatf("t3_accept%0d", i), acc, 1);
    end
    check("t3_full", cmd_ready, 0);
    push(32'h43C0_10FC, 32'hDEAD, 1'b0, acc);
    check("t3_sixth_refused", acc, 0);
    step(3);
    check("t3_still_full", {cmd_ready, busy}, 2'b01);
    aw_hold = 1'b0;
    wait_b(11, "t3_b_done");
    step(4);
    check("t3_n_aw", n_aw, 11);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_aw%0d", i), aw_log[6 + i], 32'h43C0_1000 + 32'(4 * i));
      check($sformatf("t3_w%0d", i), w_log[6 + i], 32'h10 + 32'(i));
    end
    check("t3_wr_count", wr_count, 11);
    check("t3_idle", busy, 0);

    // T4: SLVERR on second write halts, clr_err resumes
    base_aw = n_aw; base_b = n_b;
    err_at = base_b + 1;
    push(32'h43C0_4000, 32'h1, 1'b0, acc);
    push(32'h43C0_4004, 32'h2, 1'b0, acc);
    push(32'h43C0_4008, 32'h3, 1'b1, acc);
    wait_b(base_b + 2, "t4_b_err");
    check("t4_err", {err, err_resp}, {1'b1, 2'b10});
    check("t4_err_addr", err_addr, 32'h43C0_4004);
    check("t4_wr_count_hold", wr_count, 12);
    step(10);
    check("t4_no_more_aw", n_aw - base_aw, 2);
    check("t4_halt_busy", {busy, err, m_awvalid}, 3'b110);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    check("t4_err_cleared", {err, err_resp, err_timeout}, 0);
    wait_b(base_b + 3, "t4_b_resume");
    step(1);
    check("t4_resume_aw", aw_log[base_aw + 2], 32'h43C0_4008);
    check("t4_wr_count", wr_count, 13);
    check("t4_seq_cnt", seq_cnt, 2);
    err_at = -1;

    // T5: reset during ISSUE with entries queued
    aw_hold = 1'b1;
    push(32'h43C0_5000, 32'h50, 1'b0, acc);
    push(32'h43C0_5004, 32'h51, 1'b0, acc);
    push(32'h43C0_5008, 32'h52, 1'b0, acc);
    check("t5_in_issue", m_awvalid, 1);
    base_aw = n_aw;
    ARESETN = 1'b1;
    #1;
    check("t5_valids_drop", {m_awvalid, m_wvalid, m_bready}, 0);
    check("t5_fifo_empty", {busy, cmd_ready}, 2'b01);
    check("t5_wr_count", wr_count, 0);
    step(1);
    ARESETN = 1'b0;
    aw_hold = 1'b0;
    step(10);
    check("t5_no_writes", n_aw - base_aw, 0);
    check("t5_idle", busy, 0);
    base_b = n_b;
    push(32'h43C0_3000, 32'h1, 1'b1, acc);
    wait_b(base_b + 1, "t5_new_b");
    step(1);
    check("t5_new_aw", aw_log[base_aw], 32'h43C0_3000);
    check("t5_wr_count_restart", wr_count, 1);
    check("t5_seq_cnt", seq_cnt, 3);
    check("final_stable", stab_bad, 0);
    check("final_no_timeout", err_timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
